// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port owner encoding
// and the round-robin pick helper.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 6;
    localparam int unsigned DATA_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } owner_e;

    // Two-input round robin: a lone requester wins, a tie goes to the port that did not own last.
    function automatic owner_e rr_pick(input logic a_req, input logic b_req, input owner_e last);
        owner_e win;
        if (a_req && b_req) begin
            win = (last == PORT_A) ? PORT_B : PORT_A;
        end else if (b_req) begin
            win = PORT_B;
        end else begin
            win = PORT_A;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between the CPU
// (port A) and a debug/loader master (port B); one access every two cycles at best.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_done,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_done,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_in,
    output logic                  busy
);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    owner_e                last_owner_q, last_owner_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

    owner_e prio;
    owner_e winner;
    logic   any_req;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;

        // In WAIT the finishing port counts as the last owner for tie-breaking.
        prio    = (state_q == ST_WAIT) ? owner_q : last_owner_q;
        winner  = rr_pick(a_req, b_req, prio);
        any_req = a_req | b_req;

        case (state_q)
            ST_IDLE: begin
                mem_we_d = 1'b0;
            end
            ST_ISSUE: begin
                state_d  = ST_WAIT;
                mem_we_d = 1'b0;
            end
            ST_WAIT: begin
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
                mem_we_d     = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_we_d = 1'b0;
            end
        endcase

        // Capture the winner's request fields on arbitration cycles.
        if (((state_q == ST_IDLE) || (state_q == ST_WAIT)) && any_req) begin
            state_d    = ST_ISSUE;
            owner_d    = winner;
            mem_we_d   = (winner == PORT_A) ? a_we    : b_we;
            mem_addr_d = (winner == PORT_A) ? a_addr  : b_addr;
            mem_data_d = (winner == PORT_A) ? a_wdata : b_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_A;
            last_owner_q <= PORT_B;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign busy     = (state_q != ST_IDLE);

    // Grant/done are decoded from registered state and owner; read data passes straight through.
    assign a_gnt   = (state_q == ST_ISSUE) && (owner_q == PORT_A);
    assign b_gnt   = (state_q == ST_ISSUE) && (owner_q == PORT_B);
    assign a_done  = (state_q == ST_WAIT)  && (owner_q == PORT_A);
    assign b_done  = (state_q == ST_WAIT)  && (owner_q == PORT_B);
    assign a_rdata = a_done ? mem_in : '0;
    assign b_rdata = b_done ? mem_in : '0;

endmodule
